// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared state encoding and parameter defaults for the ap_ctrl driver
package ap_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int CNT_W_DEF     = 16;
    localparam int LAT_W_DEF     = 32;
    localparam int MAX_OUTST_DEF = 4;
    localparam int TIMEOUT_DEF   = 65535;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// ap_ctrl_ts_fifo: start-timestamp fifo, one entry per outstanding transaction
module ap_ctrl_ts_fifo import ap_ctrl_pkg::*; #(
    parameter int DEPTH = MAX_OUTST_DEF,
    parameter int WIDTH = LAT_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    // storage is written on push only; contents need no reset
    always_ff @(posedge ap_clk)
        if (do_push) mem[wr_ptr] <= din;
    // wrapping pointers and occupancy, cleared by reset or flush
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues ap_start/ap_continue handshakes and measures latency/interval
module ap_ctrl_driver import ap_ctrl_pkg::*; #(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LAT_W     = LAT_W_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    input  logic             cont_stall,
    output logic             ap_start,
    output logic             ap_continue,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic             run_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] done_count,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] last_interval
);
    localparam int OW   = $clog2(MAX_OUTST + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, issued;
    logic [OW-1:0] outst;
    logic [LAT_W-1:0] timer, prev_ts, head;
    logic [WD_W-1:0] wdog;
    logic abort_q, have_start, empty, full;
    logic cmd_acc, start_acc, done_acc, wd_inc, to, abort_eff, last_issue;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign start_acc  = ap_start && ap_ready;
    assign done_acc   = ap_done && ap_continue && !empty;
    assign wd_inc     = ap_start || outst != '0;
    assign to         = state != IDLE && !start_acc && !done_acc && wd_inc && wdog == WD_W'(TIMEOUT - 1);
    // an abort only takes effect once no start is left hanging without ap_ready
    assign abort_eff  = (abort || abort_q) && !(ap_start && !ap_ready);
    assign last_issue = issued + CNT_W'(start_acc) == cnt;
    ap_ctrl_ts_fifo #(.DEPTH(MAX_OUTST), .WIDTH(LAT_W)) u_fifo (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .push    (start_acc),
        .pop     (done_acc),
        .flush   (to),
        .din     (timer),
        .head    (head),
        .empty   (empty),
        .full    (full)
    );
    // state register
    always_ff @(posedge ap_clk)
        state <= !ap_rst_n ? IDLE : state_nx;
    // next-state: timeout overrides everything outside IDLE
    always_comb begin
        state_nx = state == IDLE ? (cmd_acc && cmd_count != '0 ? RUN : IDLE)
                 : to ? IDLE
                 : state == RUN ? (last_issue || abort_eff ? DRAIN : RUN)
                 : (outst == '0 ? IDLE : DRAIN);
    end
    // handshake outputs, all forced low while reset is held
    always_comb begin
        cmd_ready   = ap_rst_n && state == IDLE;
        busy        = ap_rst_n && state != IDLE;
        ap_start    = ap_rst_n && state == RUN && issued < cnt && !full;
        ap_continue = ap_rst_n && !cont_stall;
    end
    // run bookkeeping, timer, watchdog and measurements
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt           <= '0;
            issued        <= '0;
            outst         <= '0;
            done_count    <= '0;
            timer         <= '0;
            wdog          <= '0;
            prev_ts       <= '0;
            have_start    <= 1'b0;
            abort_q       <= 1'b0;
            run_done      <= 1'b0;
            timeout_err   <= 1'b0;
            last_latency  <= '0;
            last_interval <= '0;
        end else begin
            run_done <= (cmd_acc && cmd_count == '0) || (state != IDLE && state_nx == IDLE);
            abort_q  <= state == RUN && state_nx == RUN && (abort || abort_q);
            if (cmd_acc) begin
                cnt         <= cmd_count;
                issued      <= '0;
                outst       <= '0;
                done_count  <= '0;
                timeout_err <= 1'b0;
                timer       <= '0;
                wdog        <= '0;
                have_start  <= 1'b0;
            end else begin
                timer       <= state != IDLE ? timer + 1'b1 : timer;
                timeout_err <= timeout_err || to;
                outst       <= to ? '0 : outst + OW'(start_acc) - OW'(done_acc);
                wdog        <= (to || start_acc || done_acc) ? '0 : wd_inc ? wdog + 1'b1 : wdog;
                if (start_acc) begin
                    issued     <= issued + 1'b1;
                    prev_ts    <= timer;
                    have_start <= 1'b1;
                    if (have_start) last_interval <= timer - prev_ts;
                end
                if (done_acc) begin
                    done_count   <= done_count + 1'b1;
                    last_latency <= timer - head;
                end
            end
        end
    end
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: directed self-checking bench for ap_ctrl_driver
module tb_ap_ctrl_driver;
    localparam int CNT_W = 16;
    localparam int LAT_W = 32;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic abort = 1'b0;
    logic cont_stall = 1'b0;
    logic ap_ready = 1'b0;
    logic ap_done = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic cmd_ready, ap_start, ap_continue, busy, run_done, timeout_err;
    logic [CNT_W-1:0] done_count;
    logic [LAT_W-1:0] last_latency, last_interval;
    int tests = 0;
    int fails = 0;

    ap_ctrl_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .MAX_OUTST(4), .TIMEOUT(100)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .abort        (abort),
        .cont_stall   (cont_stall),
        .ap_start     (ap_start),
        .ap_continue  (ap_continue),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .busy         (busy),
        .run_done     (run_done),
        .timeout_err  (timeout_err),
        .done_count   (done_count),
        .last_latency (last_latency),
        .last_interval(last_interval)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ap_start"}, ap_start, 0);
        chk({tag, "_ap_continue"}, ap_continue, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_run_done"}, run_done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_done_count"}, done_count, 0);
        chk({tag, "_last_latency"}, last_latency, 0);
        chk({tag, "_last_interval"}, last_interval, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // reset state
        step; step;
        chk_all_zero("rst");
        ap_rst_n = 1'b1;
        step;
        chk("rst_release_ready", cmd_ready, 1);
        // single transaction, done five cycles after start
        cmd_valid = 1'b1; cmd_count = 1; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        chk("t1_start_hi", ap_start, 1);
        chk("t1_busy", busy, 1);
        step;
        chk("t1_start_lo", ap_start, 0);
        repeat (4) step;
        ap_done = 1'b1;
        step;
        ap_done = 1'b0;
        chk("t1_done_count", done_count, 1);
        chk("t1_latency", last_latency, 5);
        chk("t1_no_early_run_done", run_done, 0);
        step;
        chk("t1_run_done", run_done, 1);
        chk("t1_cmd_ready", cmd_ready, 1);
        step;
        chk("t1_run_done_pulse", run_done, 0);
        ap_done = 1'b1;
        step;
        ap_done = 1'b0;
        chk("idle_done_ignored", done_count, 1);
        // eight transactions, outstanding limit four, done ten cycles after each start
        cmd_valid = 1'b1; cmd_count = 8; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        chk("t2_done_cleared", done_count, 0);
        for (int e = 1; e <= 26; e++) begin
            ap_done = (e >= 11 && e <= 14) || (e >= 22 && e <= 25);
            step;
            if (e == 4) begin
                chk("t2_limit_start_lo", ap_start, 0);
                chk("t2_interval_burst1", last_interval, 1);
            end
            if (e == 10) chk("t2_still_limited", ap_start, 0);
            if (e == 11) chk("t2_start_resumes", ap_start, 1);
            if (e == 15) begin
                chk("t2_interval_burst2", last_interval, 1);
                chk("t2_all_issued", ap_start, 0);
            end
            if (e == 25) begin
                chk("t2_done_count", done_count, 8);
                chk("t2_latency", last_latency, 10);
                chk("t2_no_early_run_done", run_done, 0);
            end
            if (e == 26) chk("t2_run_done", run_done, 1);
        end
        ap_done = 1'b0; ap_ready = 1'b0;
        // continue stall delays done acceptance
        cmd_valid = 1'b1; cmd_count = 1; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        step;
        ap_ready = 1'b0;
        step;
        ap_done = 1'b1; cont_stall = 1'b1;
        #1;
        chk("t3_continue_lo", ap_continue, 0);
        repeat (3) step;
        chk("t3_done_held", done_count, 0);
        cont_stall = 1'b0;
        #1;
        chk("t3_continue_hi", ap_continue, 1);
        step;
        ap_done = 1'b0;
        chk("t3_done_count", done_count, 1);
        chk("t3_latency", last_latency, 5);
        step;
        chk("t3_run_done", run_done, 1);
        // watchdog timeout with no dones
        cmd_valid = 1'b1; cmd_count = 3; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        repeat (3) step;
        ap_ready = 1'b0;
        chk("t4_issued_all", ap_start, 0);
        chk("t4_busy", busy, 1);
        repeat (99) step;
        chk("t4_no_timeout_yet", timeout_err, 0);
        chk("t4_busy_before", busy, 1);
        step;
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_idle", busy, 0);
        chk("t4_cmd_ready", cmd_ready, 1);
        chk("t4_run_done", run_done, 1);
        chk("t4_start_lo", ap_start, 0);
        step;
        chk("t4_run_done_pulse", run_done, 0);
        chk("t4_sticky", timeout_err, 1);
        // abort while a start is held
        cmd_valid = 1'b1; cmd_count = 10; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        chk("t5_timeout_cleared", timeout_err, 0);
        step; step;
        ap_ready = 1'b0; abort = 1'b1;
        step;
        abort = 1'b0;
        chk("t5_start_held", ap_start, 1);
        step;
        chk("t5_start_held2", ap_start, 1);
        ap_ready = 1'b1;
        step;
        ap_ready = 1'b0;
        chk("t5_start_lo", ap_start, 0);
        chk("t5_draining", busy, 1);
        chk("t5_interval", last_interval, 3);
        step; step;
        chk("t5_no_more_start", ap_start, 0);
        ap_done = 1'b1;
        repeat (3) step;
        ap_done = 1'b0;
        chk("t5_done_count", done_count, 3);
        chk("t5_latency", last_latency, 5);
        step;
        chk("t5_run_done", run_done, 1);
        // reset mid-run with two outstanding
        cmd_valid = 1'b1; cmd_count = 5; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        step; step;
        ap_ready = 1'b0;
        chk("t6_busy", busy, 1);
        ap_rst_n = 1'b0;
        step;
        chk_all_zero("t6_rst");
        ap_rst_n = 1'b1;
        step;
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_no_run_done", run_done, 0);
        cmd_valid = 1'b1; cmd_count = 0;
        step;
        cmd_valid = 1'b0;
        chk("t6_zero_run_done", run_done, 1);
        chk("t6_zero_idle", busy, 0);
        step;
        chk("t6_zero_pulse", run_done, 0);
        cmd_valid = 1'b1; cmd_count = 1; ap_ready = 1'b1;
        step;
        cmd_valid = 1'b0;
        step;
        ap_ready = 1'b0;
        step;
        ap_done = 1'b1;
        step;
        ap_done = 1'b0;
        chk("t6_post_rst_latency", last_latency, 2);
        chk("t6_post_rst_done", done_count, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ap_ctrl_driver.md
AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of transaction counts.
REQ-002 SHALL have parameter LAT_W, default 32, width of cycle timer and latency/interval results.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum started-but-not-done transactions (range 1..16).
REQ-004 SHALL have parameter TIMEOUT, default 65535, watchdog limit in cycles.
REQ-005 SHALL have a single clock; reset is synchronous and active-low.
REQ-006 SHALL have these ports (name  direction  width  meaning):
- ap_clk  in  1  sole clock, all logic on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  run request
- cmd_ready  out  1  high only in IDLE, out of reset
- cmd_count  in  CNT_W  transactions to issue; 0 means no-op
- abort  in  1  stop issuing; drain outstanding
- cont_stall  in  1  hold ap_continue low
- ap_start  out  1  DUT start
- ap_continue  out  1  DUT continue
- ap_ready  in  1  DUT accepted start
- ap_done  in  1  DUT finished a transaction
- busy  out  1  state not IDLE
- run_done  out  1  one-cycle end-of-run pulse
- timeout_err  out  1  sticky watchdog flag
- done_count  out  CNT_W  dones accepted this run
- last_latency  out  LAT_W  start-accept to done-accept cycles, latest transaction
- last_interval  out  LAT_W  cycles between the last two start accepts

Function
REQ-007 SHALL accept a command on cmd_valid&cmd_ready, latch cmd_count, and clear done_count, timeout_err and the cycle timer.
REQ-008 SHALL use states IDLE, RUN and DRAIN: IDLE->RUN on accept with count>0; RUN->DRAIN when issued==count or abort; DRAIN->IDLE when outstanding==0.
REQ-009 SHALL, on accepting cmd_count==0, pulse run_done on the next cycle and remain in IDLE.
REQ-010 SHALL assert ap_start in RUN when issued<count and outstanding<MAX_OUTST, and never deassert it before ap_ready is seen.
REQ-011 SHALL treat ap_start&ap_ready as a start accept: issued+1, outstanding+1, and push the timer value into the timestamp FIFO.
REQ-012 SHALL drive ap_continue = ~cont_stall, and treat ap_done&ap_continue as a done accept: outstanding-1, done_count+1.
REQ-013 SHALL leave outstanding unchanged when a start accept and a done accept occur in the same cycle.
REQ-014 SHALL ignore a done accept when outstanding==0: no count change, no FIFO pop.
REQ-015 SHALL, on a done accept, pop the FIFO head and set last_latency = timer - head, computed modulo 2^LAT_W.
REQ-016 SHALL, on each start accept after the first in a run, set last_interval = timer - previous start timestamp; the first start of a run leaves last_interval unchanged.
REQ-017 SHALL increment the timer every cycle in RUN/DRAIN, wrapping modulo 2^LAT_W.
REQ-018 SHALL, on abort in RUN, complete any held ap_start handshake before entering DRAIN; abort is ignored in IDLE and DRAIN.
REQ-019 SHALL clear the watchdog on any accept, and otherwise increment it while ap_start or outstanding>0.
REQ-020 SHALL, when the watchdog reaches TIMEOUT, set timeout_err, drop ap_start, flush the FIFO, go to IDLE and pulse run_done.
REQ-021 SHALL pulse run_done for exactly one cycle on every DRAIN->IDLE transition.

Reset
REQ-022 SHALL, while ap_rst_n=0, set state IDLE and drive ap_start, ap_continue, cmd_ready, busy, run_done, timeout_err, done_count, last_latency, last_interval, the timer, the watchdog and the FIFO pointers to 0.
REQ-023 SHALL, on reset mid-run, abandon all outstanding transactions with no run_done pulse, and assert cmd_ready on the first cycle after release.

Structure
REQ-024 SHALL take the state enum and the parameter defaults from shared package ap_ctrl_pkg.
REQ-025 SHALL use one sub-module, ap_ctrl_ts_fifo (depth MAX_OUTST, width LAT_W, with push, pop, flush, head, empty and full), for start timestamps.

Verification
REQ-026 count=1; ap_ready with ap_start; ap_done 5 cycles later -> ap_start high 1 cycle, last_latency=5, done_count=1, one run_done pulse.
REQ-027 count=8, MAX_OUTST=4, ap_ready always high, done 10 cycles after each start -> ap_start low after 4 issues until first done; last_interval=1 within bursts; done_count=8.
REQ-028 cont_stall high 3 cycles while ap_done high -> ap_continue low, done not counted until release, last_latency includes the 3 stall cycles.
REQ-029 TIMEOUT=100, count=3, DUT never asserts ap_done -> timeout_err at watchdog=100, ap_start low, IDLE, run_done pulse, cmd_ready=1.
REQ-030 count=10, abort after 2 accepts while ap_start held -> third handshake completes, no further ap_start, DRAIN, done_count=3.
REQ-031 reset mid-run with 2 outstanding -> all outputs 0 during reset; cmd_ready=1 the cycle after release; a new count=0 command -> run_done pulse next cycle.
